// File: rtl/alsu.sv
// Purpose     : registered arithmetic/logic/shift unit on two 3-bit signed operands.
// Latency     : 2 edges; inputs sampled at posedge N, out/leds update at posedge N+1.
// Backpressure: none; a new operation is accepted every cycle and no stall exists.
//
// Ports
//   clk                 rising-edge clock
//   rst                 synchronous active-high reset (clears input regs, out, leds)
//   A, B [2:0]          signed operands
//   cin                 carry-in for ADD (ignored when FULL_ADDER != "ON")
//   serial_in           fill bit for SHIFT
//   red_op_A/red_op_B   reduction selects for OR/XOR
//   bypass_A/bypass_B   pass an operand straight to out (highest priority)
//   direction           1 = left, 0 = right (SHIFT/ROTATE)
//   opcode [2:0]        0 OR, 1 XOR, 2 ADD, 3 MULT, 4 SHIFT, 5 ROTATE, 6/7 invalid
//   leds [15:0]         invalid-operation indicator
//   out  [5:0]          signed result
//
// Parameters
//   INPUT_PRIORITY      "A" or "B": operand that wins when both A- and B-side selects are set
//   FULL_ADDER          "ON" adds cin in ADD, anything else ignores it
//
// Build option
//   ALSU_LED_BLINK_EN   defined: leds toggle every cycle while the registered operation is
//                       invalid and read 0 otherwise. Undefined: leds stay 0.

module alsu #(
  parameter string INPUT_PRIORITY = "A",
  parameter string FULL_ADDER     = "ON"
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  A,
  input  logic [2:0]  B,
  input  logic        cin,
  input  logic        serial_in,
  input  logic        red_op_A,
  input  logic        red_op_B,
  input  logic        bypass_A,
  input  logic        bypass_B,
  input  logic        direction,
  input  logic [2:0]  opcode,
  output logic [15:0] leds,
  output logic [5:0]  out
);

  localparam logic [2:0] OP_OR     = 3'd0;
  localparam logic [2:0] OP_XOR    = 3'd1;
  localparam logic [2:0] OP_ADD    = 3'd2;
  localparam logic [2:0] OP_MULT   = 3'd3;
  localparam logic [2:0] OP_SHIFT  = 3'd4;
  localparam logic [2:0] OP_ROTATE = 3'd5;

  localparam bit PRIO_A  = (INPUT_PRIORITY == "A");
  localparam bit USE_CIN = (FULL_ADDER == "ON");

  // ---------------------------------------------------------------------------
  // Input register stage
  // ---------------------------------------------------------------------------
  logic [2:0] a_q, a_d;
  logic [2:0] b_q, b_d;
  logic       cin_q, cin_d;
  logic       serial_q, serial_d;
  logic       red_a_q, red_a_d;
  logic       red_b_q, red_b_d;
  logic       byp_a_q, byp_a_d;
  logic       byp_b_q, byp_b_d;
  logic       dir_q, dir_d;
  logic [2:0] opcode_q, opcode_d;

  always_comb begin
    a_d      = A;
    b_d      = B;
    cin_d    = cin;
    serial_d = serial_in;
    red_a_d  = red_op_A;
    red_b_d  = red_op_B;
    byp_a_d  = bypass_A;
    byp_b_d  = bypass_B;
    dir_d    = direction;
    opcode_d = opcode;
  end

  // ---------------------------------------------------------------------------
  // Output register stage
  // ---------------------------------------------------------------------------
  logic [5:0]  out_q, out_d;
  logic [15:0] leds_q, leds_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      serial_q <= 1'b0;
      red_a_q  <= 1'b0;
      red_b_q  <= 1'b0;
      byp_a_q  <= 1'b0;
      byp_b_q  <= 1'b0;
      dir_q    <= 1'b0;
      opcode_q <= '0;
      out_q    <= '0;
      leds_q   <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      serial_q <= serial_d;
      red_a_q  <= red_a_d;
      red_b_q  <= red_b_d;
      byp_a_q  <= byp_a_d;
      byp_b_q  <= byp_b_d;
      dir_q    <= dir_d;
      opcode_q <= opcode_d;
      out_q    <= out_d;
      leds_q   <= leds_d;
    end
  end

  assign out  = out_q;
  assign leds = leds_q;

  // ---------------------------------------------------------------------------
  // Datapath on the registered operands
  // ---------------------------------------------------------------------------
  logic signed [5:0] a_ext;
  logic signed [5:0] b_ext;
  logic              cin_eff;
  logic              red_pick_a;   // reduction operand choice when red selects are set
  logic [2:0]        red_operand;
  logic              invalid;
  logic [5:0]        result;

  // Sign extension to the result width; ADD and MULT then wrap modulo 64 naturally.
  assign a_ext   = {{3{a_q[2]}}, a_q};
  assign b_ext   = {{3{b_q[2]}}, b_q};
  assign cin_eff = cin_q & USE_CIN;

  // Both reduction selects set -> INPUT_PRIORITY decides which operand is reduced.
  assign red_pick_a  = red_a_q & (~red_b_q | PRIO_A);
  assign red_operand = red_pick_a ? a_q : b_q;

  // Reduction is only meaningful for OR/XOR; any other opcode with a reduction
  // select is treated as invalid, as are the two unused opcodes.
  always_comb begin
    invalid = 1'b0;
    if (opcode_q > OP_ROTATE) begin
      invalid = 1'b1;
    end else if ((red_a_q | red_b_q) && (opcode_q != OP_OR) && (opcode_q != OP_XOR)) begin
      invalid = 1'b1;
    end
  end

  always_comb begin
    result = '0;
    case (opcode_q)
      OP_OR: begin
        if (red_a_q | red_b_q) begin
          result = {5'b0, |red_operand};
        end else begin
          result = a_ext | b_ext;
        end
      end
      OP_XOR: begin
        if (red_a_q | red_b_q) begin
          result = {5'b0, ^red_operand};
        end else begin
          result = a_ext ^ b_ext;
        end
      end
      OP_ADD:    result = a_ext + b_ext + $signed({5'b0, cin_eff});
      OP_MULT:   result = a_ext * b_ext;
      // SHIFT/ROTATE act on the value currently presented on out.
      OP_SHIFT:  result = dir_q ? {out_q[4:0], serial_q} : {serial_q, out_q[5:1]};
      OP_ROTATE: result = dir_q ? {out_q[4:0], out_q[5]} : {out_q[0], out_q[5:1]};
      default:   result = '0;
    endcase
  end

  // Bypass beats everything, including an invalid opcode; leds still follow
  // the validity of the opcode/reduction combination regardless of bypass.
  always_comb begin
    out_d = result;
    if (byp_a_q && byp_b_q) begin
      out_d = PRIO_A ? a_ext : b_ext;
    end else if (byp_a_q) begin
      out_d = a_ext;
    end else if (byp_b_q) begin
      out_d = b_ext;
    end else if (invalid) begin
      out_d = '0;
    end
  end

`ifdef ALSU_LED_BLINK_EN
  always_comb begin
    leds_d = '0;
    if (invalid) begin
      leds_d = ~leds_q;
    end
  end
`else
  always_comb begin
    leds_d = '0;
  end
`endif

endmodule

// File: tb/tb_alsu.sv
// Purpose     : self-checking bench for alsu (default parameters).
// Latency     : model mirrors the 2-edge input->out timing.
// Backpressure: n/a.

module tb_alsu;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  A, B, opcode;
  logic        cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction;
  logic [15:0] leds;
  logic [5:0]  out;

  alsu dut (
    .clk       (clk),
    .rst       (rst),
    .A         (A),
    .B         (B),
    .cin       (cin),
    .serial_in (serial_in),
    .red_op_A  (red_op_A),
    .red_op_B  (red_op_B),
    .bypass_A  (bypass_A),
    .bypass_B  (bypass_B),
    .direction (direction),
    .opcode    (opcode),
    .leds      (leds),
    .out       (out)
  );

  always #5 clk = ~clk;

  localparam bit PRIO_A = 1'b1;   // INPUT_PRIORITY default "A"
  localparam bit FA_ON  = 1'b1;   // FULL_ADDER default "ON"

`ifdef ALSU_LED_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] a, b, op;
    logic cin, sin, ra, rb, ba, bb, dir;
  } in_t;

  in_t         pend;
  logic [5:0]  exp_out;
  logic [15:0] exp_leds;

  function automatic int sval(input logic [2:0] v);
    return (v > 3'd3) ? int'(v) - 8 : int'(v);
  endfunction

  function automatic bit is_invalid(input in_t p);
    return (p.op > 3'd5) || ((p.ra || p.rb) && (p.op > 3'd1));
  endfunction

  // Reference result computed with plain integer arithmetic, reduced mod 64.
  function automatic logic [5:0] ref_out(input in_t p, input logic [5:0] cur);
    int sa, sb, c, v, s;
    bit pick_a;
    logic [2:0] opnd;
    sa = sval(p.a);
    sb = sval(p.b);
    c  = int'(cur);
    s  = int'(p.sin);
    v  = 0;
    if (p.ba || p.bb) begin
      pick_a = p.ba && (!p.bb || PRIO_A);
      v = pick_a ? sa : sb;
    end else if (is_invalid(p)) begin
      v = 0;
    end else begin
      case (p.op)
        3'd0, 3'd1: begin
          if (p.ra || p.rb) begin
            pick_a = p.ra && (!p.rb || PRIO_A);
            opnd = pick_a ? p.a : p.b;
            v = (p.op == 3'd0) ? int'(opnd != 3'd0) : ($countones(opnd) % 2);
          end else begin
            v = (p.op == 3'd0) ? (sa | sb) : (sa ^ sb);
          end
        end
        3'd2: v = sa + sb + ((FA_ON && p.cin) ? 1 : 0);
        3'd3: v = sa * sb;
        3'd4: v = p.dir ? (c * 2 + s) : (s * 32 + c / 2);
        3'd5: v = p.dir ? (c * 2 + c / 32) : ((c % 2) * 32 + c / 2);
        default: v = 0;
      endcase
    end
    return v[5:0];
  endfunction

  // Advance one clock edge and update the model, then settle 1 time unit past the edge.
  task automatic tick();
    bit inv;
    @(posedge clk);
    if (rst) begin
      exp_out  = '0;
      exp_leds = '0;
      pend     = '{default: '0};
    end else begin
      inv      = is_invalid(pend);
      exp_out  = ref_out(pend, exp_out);
      exp_leds = (BLINK && inv) ? ~exp_leds : 16'h0000;
      pend.a   = A;         pend.b   = B;        pend.op  = opcode;
      pend.cin = cin;       pend.sin = serial_in;
      pend.ra  = red_op_A;  pend.rb  = red_op_B;
      pend.ba  = bypass_A;  pend.bb  = bypass_B; pend.dir = direction;
    end
    #1;
  endtask

  task automatic set_idle();
    rst = 1'b0; A = '0; B = '0; opcode = '0; cin = 1'b0; serial_in = 1'b0;
    red_op_A = 1'b0; red_op_B = 1'b0; bypass_A = 1'b0; bypass_B = 1'b0; direction = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (out !== 6'd0) begin errors++; $display("FAIL reset_out: got %h want 00", out); end
    checks++;
    if (leds !== 16'h0000) begin errors++; $display("FAIL reset_leds: got %h want 0000", leds); end
    rst = 1'b0;
    tick();
    tick();
    // Shift 1,0,1,0,1 in from the right to build 6'h15, then reset over it.
    opcode = 3'd4; direction = 1'b1;
    for (int i = 0; i < 6; i++) begin
      serial_in = (i % 2 == 0) && (i < 5);
      tick();
    end
    checks++;
    if (out !== 6'h15) begin errors++; $display("FAIL prior_out_15: got %h want 15", out); end
    rst = 1'b1;
    tick();
    checks++;
    if (out !== 6'd0 || leds !== 16'h0000)
      begin errors++; $display("FAIL reset_over_15: got out=%h leds=%h want 00/0000", out, leds); end
    set_idle();
  endtask

  task automatic test_add_mult();
    set_idle();
    opcode = 3'd2; A = 3'd3; B = 3'd2; cin = 1'b1;
    tick();
    opcode = 3'd3; A = 3'b100; B = 3'd3; cin = 1'b0;
    tick();
    checks++;
    if (out !== 6'd6 || leds !== 16'h0000)
      begin errors++; $display("FAIL add_3_2_1: got out=%h leds=%h want 06/0000", out, leds); end
    opcode = 3'd2; A = 3'b100; B = 3'b100; cin = 1'b0;
    tick();
    checks++;
    if (out !== 6'b110100) begin errors++; $display("FAIL mult_m4_3: got %b want 110100", out); end
    tick();
    checks++;
    if (out !== 6'b111000) begin errors++; $display("FAIL add_m4_m4: got %b want 111000", out); end
  endtask

  task automatic test_or_xor();
    set_idle();
    opcode = 3'd0; red_op_A = 1'b1; A = 3'b010; B = 3'b000;
    tick();
    opcode = 3'd1; red_op_A = 1'b1; red_op_B = 1'b1; A = 3'b011; B = 3'b001;
    tick();
    checks++;
    if (out !== 6'd1) begin errors++; $display("FAIL or_red_a: got %h want 01", out); end
    tick();
    checks++;
    if (out !== 6'd0) begin errors++; $display("FAIL xor_red_both_prio_a: got %h want 00", out); end
  endtask

  task automatic test_shift_rotate();
    set_idle();
    opcode = 3'd2; A = 3'd3; B = 3'd2; cin = 1'b1;
    tick();
    opcode = 3'd4; direction = 1'b1; serial_in = 1'b1;
    tick();
    checks++;
    if (out !== 6'b000110) begin errors++; $display("FAIL sr_seed: got %b want 000110", out); end
    opcode = 3'd5; direction = 1'b0;
    tick();
    checks++;
    if (out !== 6'b001101) begin errors++; $display("FAIL shift_left: got %b want 001101", out); end
    tick();
    checks++;
    if (out !== 6'b100110) begin errors++; $display("FAIL rotate_right: got %b want 100110", out); end
  endtask

  task automatic test_invalid_blink();
    logic [15:0] want [3];
    want[0] = BLINK ? 16'hFFFF : 16'h0000;
    want[1] = 16'h0000;
    want[2] = BLINK ? 16'hFFFF : 16'h0000;
    set_idle();
    tick();
    opcode = 3'd6;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out !== 6'd0 || leds !== want[i])
        begin errors++; $display("FAIL invalid_cycle%0d: got out=%h leds=%h want 00/%h", i, out, leds, want[i]); end
    end
    bypass_A = 1'b1; bypass_B = 1'b1; A = 3'b110; B = 3'b001;
    tick();
    tick();
    checks++;
    if (out !== 6'b111110) begin errors++; $display("FAIL bypass_both_invalid: got %b want 111110", out); end
  endtask

  task automatic test_reset_mid();
    set_idle();
    opcode = 3'd2; A = 3'd3; B = 3'd3; cin = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (out !== 6'd0) begin errors++; $display("FAIL mid_reset_out: got %h want 00", out); end
    rst = 1'b0; A = 3'd1; B = 3'd1; cin = 1'b0;
    tick();
    checks++;
    if (out !== 6'd0) begin errors++; $display("FAIL mid_reset_discard: got %h want 00", out); end
    tick();
    checks++;
    if (out !== 6'd2) begin errors++; $display("FAIL mid_reset_first: got %h want 02", out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 39) == 0);
      A         = 3'($urandom_range(0, 7));
      B         = 3'($urandom_range(0, 7));
      opcode    = 3'($urandom_range(0, 7));
      cin       = 1'($urandom_range(0, 1));
      serial_in = 1'($urandom_range(0, 1));
      direction = 1'($urandom_range(0, 1));
      red_op_A  = ($urandom_range(0, 3) == 0);
      red_op_B  = ($urandom_range(0, 3) == 0);
      bypass_A  = ($urandom_range(0, 7) == 0);
      bypass_B  = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (out !== exp_out || leds !== exp_leds)
        begin errors++; $display("FAIL random%0d: got out=%h leds=%h want %h/%h", i, out, leds, exp_out, exp_leds); end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    rst = 1'b1;
    test_reset();
    test_add_mult();
    test_or_xor();
    test_shift_rotate();
    test_invalid_blink();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
